// File: rtl/nixie_pkg.sv
// nixie_pkg: shared types and constants for the Nixie display scheduler
package nixie_pkg;
   typedef enum logic [1:0] {IDLE, CONV, SHIFT, LATCH} state_t;
   localparam int NUM_FIELDS = 3;
   localparam int FRAME_BITS = 24;
   localparam logic [3:0] BCD_BLANK = 4'hF;
endpackage

// File: rtl/nixie_display_scheduler_bin2bcd.sv
// bin2bcd: combinational 8-bit binary to three-digit BCD (double dabble)
module bin2bcd (
   input  logic [7:0] bin,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);
   logic [11:0] bcd;
   // Add-3 correction on each digit before shifting in the next binary bit
   always_comb begin
      bcd = 12'd0;
      for (int i = 7; i >= 0; i--) begin
         bcd[3:0] = bcd[3:0] > 4'd4 ? bcd[3:0] + 4'd3 : bcd[3:0];
         bcd[7:4] = bcd[7:4] > 4'd4 ? bcd[7:4] + 4'd3 : bcd[7:4];
         bcd[11:8] = bcd[11:8] > 4'd4 ? bcd[11:8] + 4'd3 : bcd[11:8];
         bcd = {bcd[10:0], bin[i]};
      end
   end
   assign {hundreds, tens, ones} = bcd;
endmodule

// File: rtl/nixie_display_scheduler.sv
// nixie_display_scheduler: converts H/M/S to BCD, shifts the 24-bit frame to the Nixie driver, latches it
module nixie_display_scheduler
   import nixie_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            hours,
   input  logic [7:0]            minutes,
   input  logic [7:0]            seconds,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err,
   output logic [FRAME_BITS-1:0] digits,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  slatch
);
   state_t                state;
   logic [7:0]            sh_h, sh_m, sh_s, field, conv_byte, div_cnt;
   logic [1:0]            idx;
   logic [4:0]            bit_cnt;
   logic [FRAME_BITS-1:0] frame;
   logic [3:0]            hun, ten, one;
   logic                  half_end;

   // Field mux into the shared converter, blanking out-of-range values
   always_comb begin
      field = idx == 2'd0 ? sh_h : idx == 2'd1 ? sh_m : sh_s;
      conv_byte = hun != 4'd0 ? {BCD_BLANK, BCD_BLANK} : {ten, one};
      half_end = div_cnt == 8'(CLK_DIV - 1);
   end

   bin2bcd u_conv (
      .bin(field),
      .hundreds(hun),
      .tens(ten),
      .ones(one)
   );

   // Refresh sequencer: capture, convert, serialise, latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         range_err <= 1'b0;
         digits <= '0;
         sclk <= 1'b0;
         sdata <= 1'b0;
         slatch <= 1'b0;
         sh_h <= '0;
         sh_m <= '0;
         sh_s <= '0;
         idx <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         frame <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               // the done cycle is still part of the refresh, so a start there is dropped
               if (start && !done) begin
                  sh_h <= hours;
                  sh_m <= minutes;
                  sh_s <= seconds;
                  range_err <= 1'b0;
                  idx <= '0;
                  busy <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               frame <= {frame[FRAME_BITS-9:0], conv_byte};
               range_err <= range_err | (hun != 4'd0);
               idx <= idx + 2'd1;
               if (idx == 2'(NUM_FIELDS - 1)) begin
                  bit_cnt <= 5'(FRAME_BITS - 1);
                  div_cnt <= '0;
                  sclk <= 1'b0;
                  // frame is still being shifted this edge; hours MSB currently sits at bit 15
                  sdata <= frame[FRAME_BITS-9];
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
               if (half_end) begin
                  sclk <= ~sclk;
                  if (sclk && bit_cnt == 5'd0) begin
                     slatch <= 1'b1;
                     digits <= frame;
                     state <= LATCH;
                  end else if (sclk) begin
                     bit_cnt <= bit_cnt - 5'd1;
                     sdata <= frame[bit_cnt - 5'd1];
                  end
               end
            end
            LATCH: begin
               div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
               if (half_end) begin
                  slatch <= 1'b0;
                  done <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nixie_display_scheduler.sv
// tb_nixie_display_scheduler: checks three CLK_DIV variants against a decimal-digit reference model
module tb_nixie_display_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] hours = 8'd0, minutes = 8'd0, seconds = 8'd0;
   logic [2:0] busy, done, range_err, sclk, sdata, slatch;
   logic [23:0] digits [3];
   int cyc = 0;
   int checks = 0, errors = 0;
   logic [23:0] shown = 24'h0;

   int m_rises [3], m_viol [3], m_lp [3], m_lw [3], m_dc [3], m_da [3], m_br [3], m_ba [3], m_lb [3];
   logic [23:0] m_bits [3], m_dl [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = g == 0 ? 4 : g == 1 ? 1 : 7;
      int rises, viol, lp, lw, dc, da, br, ba, lb;
      logic [23:0] bits, dl;
      logic p_sclk, p_sdata, p_slatch, p_busy;

      nixie_display_scheduler #(.CLK_DIV(D)) dut (
         .clk(clk),
         .rst(rst),
         .start(start),
         .hours(hours),
         .minutes(minutes),
         .seconds(seconds),
         .busy(busy[g]),
         .done(done[g]),
         .range_err(range_err[g]),
         .digits(digits[g]),
         .sclk(sclk[g]),
         .sdata(sdata[g]),
         .slatch(slatch[g])
      );

      // Serial-line observer: records bits, edges, latch pulses and timing
      always @(negedge clk) begin
         if (clr) begin
            rises <= 0; viol <= 0; lp <= 0; lw <= 0; dc <= 0; da <= 0;
            br <= 0; ba <= 0; lb <= 0; bits <= '0; dl <= '0;
         end else begin
            if (sclk[g] && !p_sclk) begin
               rises <= rises + 1;
               bits <= {bits[22:0], sdata[g]};
            end
            if (sclk[g] && p_sclk && sdata[g] !== p_sdata) viol <= viol + 1;
            if (slatch[g] && !p_slatch) begin
               lp <= lp + 1;
               lw <= 1;
               dl <= digits[g];
               if (sclk[g]) lb <= lb + 1;
            end else if (slatch[g]) lw <= lw + 1;
            if (done[g]) begin
               dc <= dc + 1;
               da <= cyc;
            end
            if (busy[g] && !p_busy) begin
               br <= br + 1;
               ba <= cyc;
            end
         end
         p_sclk <= sclk[g];
         p_sdata <= sdata[g];
         p_slatch <= slatch[g];
         p_busy <= busy[g];
      end

      assign m_rises[g] = rises;
      assign m_viol[g] = viol;
      assign m_lp[g] = lp;
      assign m_lw[g] = lw;
      assign m_dc[g] = dc;
      assign m_da[g] = da;
      assign m_br[g] = br;
      assign m_ba[g] = ba;
      assign m_lb[g] = lb;
      assign m_bits[g] = bits;
      assign m_dl[g] = dl;
   end

   function automatic int div_of(input int i);
      return i == 0 ? 4 : i == 1 ? 1 : 7;
   endfunction

   // Two decimal digits per field, or the blank code when the value needs three
   function automatic logic [7:0] enc(input int v);
      return v > 99 ? 8'hFF : 8'((v / 10) * 16 + v % 10);
   endfunction

   function automatic bit all_done();
      return m_dc[0] >= 1 && m_dc[1] >= 1 && m_dc[2] >= 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh(input int h, input int m, input int s, input bit mutate);
      logic [23:0] e;
      bit er;
      int k, n;
      e = {enc(h), enc(m), enc(s)};
      er = h > 99 || m > 99 || s > 99;
      @(posedge clk); #1;
      hours = 8'(h); minutes = 8'(m); seconds = 8'(s); start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      k = cyc; start = 1'b0; clr = 1'b0;
      n = 0;
      while (!all_done() && n < 1000) begin
         @(posedge clk); #1;
         if (n == 3) begin
            chk("rerr_after_conv", 64'(range_err[0]), 64'(er));
            chk("digits_hold", 64'(digits[0]), 64'(shown));
         end
         if (mutate && n == 100) begin
            hours = 8'($urandom); minutes = 8'($urandom); seconds = 8'($urandom);
         end
         n++;
      end
      chk("refresh_finished", 64'(all_done()), 64'd1);
      @(negedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rises_d%0d", div_of(i)), 64'(m_rises[i]), 64'd24);
         chk($sformatf("stream_d%0d", div_of(i)), 64'(m_bits[i]), 64'(e));
         chk($sformatf("sdata_stable_d%0d", div_of(i)), 64'(m_viol[i]), 64'd0);
         chk($sformatf("latch_pulses_d%0d", div_of(i)), 64'(m_lp[i]), 64'd1);
         chk($sformatf("latch_width_d%0d", div_of(i)), 64'(m_lw[i]), 64'(div_of(i)));
         chk($sformatf("latch_sclk_low_d%0d", div_of(i)), 64'(m_lb[i]), 64'd0);
         chk($sformatf("digits_at_latch_d%0d", div_of(i)), 64'(m_dl[i]), 64'(e));
         chk($sformatf("digits_d%0d", div_of(i)), 64'(digits[i]), 64'(e));
         chk($sformatf("done_count_d%0d", div_of(i)), 64'(m_dc[i]), 64'd1);
         // done sits in cycle k+4+49*D, i.e. 49*D+3 edges after the sampling edge k
         chk($sformatf("done_latency_d%0d", div_of(i)), 64'(m_da[i] - k), 64'(49 * div_of(i) + 3));
         chk($sformatf("range_err_d%0d", div_of(i)), 64'(range_err[i]), 64'(er));
         chk($sformatf("busy_idle_d%0d", div_of(i)), 64'(busy[i]), 64'd0);
      end
      shown = e;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_outputs_d%0d", div_of(i)),
             64'({busy[i], done[i], range_err[i], sclk[i], sdata[i], slatch[i], digits[i]}), 64'd0);
      rst = 1'b0;

      refresh(12, 34, 56, 1'b0);
      refresh(0, 9, 99, 1'b0);
      refresh(10, 90, 59, 1'b0);
      refresh(5, 150, 42, 1'b0);
      refresh(7, 8, 9, 1'b0);
      refresh(23, 45, 7, 1'b1);
      for (int r = 0; r < 4; r++)
         refresh(int'($urandom_range(0, 120)), int'($urandom_range(0, 120)), int'($urandom_range(0, 120)), 1'b1);

      @(posedge clk); #1;
      hours = 8'd21; minutes = 8'd43; seconds = 8'd8; start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      start = 1'b0;
      chk("hold_one_done", 64'(m_dc[0]), 64'd1);
      chk("hold_two_starts", 64'(m_br[0]), 64'd2);
      chk("hold_restart_gap", 64'(m_ba[0] - m_da[0]), 64'd2);
      chk("hold_digits", 64'(digits[0]), 64'h214308);
      n = 0;
      while ((m_dc[0] < 2 || busy != 3'b000) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_second_done", 64'(m_dc[0]), 64'd2);
      chk("hold_drained", 64'(busy), 64'd0);
      shown = 24'h214308;

      @(posedge clk); #1;
      hours = 8'd8; minutes = 8'd150; seconds = 8'd1; start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      repeat (90) @(posedge clk);
      #1;
      chk("rerr_before_reset", 64'(range_err[0]), 64'd1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("async_reset_d%0d", div_of(i)),
             64'({busy[i], done[i], range_err[i], sclk[i], sdata[i], slatch[i], digits[i]}), 64'd0);
      chk("no_partial_latch", 64'(m_lp[0]), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      shown = 24'h0;
      refresh(19, 59, 30, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nixie_display_scheduler.md
# nixie_display_scheduler

Time-multiplexes a single binary-to-BCD converter across the hours, minutes and seconds fields of the clock. It packs the six resulting BCD digits into a 24-bit frame and shifts the frame serially into the Nixie high-voltage driver chain, then strobes the driver latch. It sits between the timekeeping counters and the off-chip driver pins; one `start` pulse produces one display refresh.

## Interface
- `CLK_DIV`, default 4: system clocks per serial-clock half period; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  refresh request, sampled on `clk`.
- `hours`  in  8  binary hours; legal range 0..99.
- `minutes`  in  8  binary minutes; legal range 0..99.
- `seconds`  in  8  binary seconds; legal range 0..99.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the refresh completes.
- `range_err`  out  1  sticky; set when any captured field exceeds 99; cleared on the next accepted `start`.
- `digits`  out  24  latched frame {H10,H1,M10,M1,S10,S1}, 4 bits each.
- `sclk`  out  1  driver serial clock.
- `sdata`  out  1  driver serial data.
- `slatch`  out  1  driver latch strobe, active high.

## Operation
- States: IDLE → CONV → SHIFT → LATCH → IDLE.
- IDLE:
  - `start`=1 captures `hours`, `minutes` and `seconds` into shadow registers.
  - Clears `range_err` and the field index, then goes to CONV.
  - `start` outside IDLE is ignored; requests are not queued.
- CONV: three cycles, index 0,1,2 selects the hours, minutes and seconds shadow respectively.
  - The converter output is stored into the corresponding byte of the 24-bit shift frame.
  - If the converter's hundreds nibble is non-zero, the byte becomes 8'hFF (blank code) and `range_err` is set.
  - After index 2, the bit counter loads 23 and the state goes to SHIFT.
- SHIFT: 24 bits, MSB first (H10 bit 3 first).
  - Each bit is `sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `sdata` changes only on the cycle `sclk` goes low; it is stable while `sclk` is high.
  - After the 24th high phase, `sclk` returns low and the state goes to LATCH.
- LATCH:
  - `slatch` is high for exactly `CLK_DIV` cycles.
  - `digits` loads the frame on the first LATCH cycle.
  - On exit: `done` pulses, then IDLE.
- `digits` changes only in LATCH, so it always matches what the driver displays.

## Timing
- Reset values:
  - Outputs `busy`, `done`, `range_err`, `sclk`, `sdata` and `slatch` all reset to 0.
  - `digits` resets to 24'h0; the state resets to IDLE.
  - Counters and shadow registers reset to 0.
- Latency, with `start` sampled high at edge k:
  - CONV occupies cycles k+1..k+3.
  - SHIFT occupies 48·`CLK_DIV` cycles.
  - LATCH occupies `CLK_DIV` cycles.
  - `done` is high in cycle k+4+49·`CLK_DIV` (200 for `CLK_DIV`=4).
- `busy` is high from cycle k+1 through the `done` cycle inclusive.
- Back-to-back: `start` high in the `done` cycle is ignored; it is accepted the following cycle (IDLE).
- Input changes after capture do not affect the frame in flight.
- Reset mid-operation:
  - Immediate return to IDLE, with `sclk` and `slatch` low.
  - A partial frame is never latched, so the display keeps its previous content; `digits` reads 0.
- Converter: a purely combinational path from shadow byte to the frame register, one conversion per cycle; it must close timing at the system clock.

## Structure
- Shared package `nixie_pkg`:
  - State enum (IDLE, CONV, SHIFT, LATCH).
  - `NUM_FIELDS`=3, `FRAME_BITS`=24, `BCD_BLANK`=4'hF.
- One sub-module: the existing 8-bit `bin2bcd` converter, instantiated once and driven by a 3:1 mux on the field index.
- Everything else (half-period counter, bit counter, shift register, FSM) is inline.

## Test plan
- Basic refresh:
  - Stimulus: `hours`=12, `minutes`=34, `seconds`=56, `CLK_DIV`=4, `start` pulse.
  - Required: serial stream 0001_0010_0011_0100_0101_0110; `digits`=24'h123456; `done` at cycle k+200; `range_err`=0.
- Boundaries:
  - Stimulus: inputs 0, 9, 99.
  - Required: `digits`=24'h000999.
  - Stimulus: inputs 10, 90, 59.
  - Required: `digits`=24'h109059.
- Range error:
  - Stimulus: `minutes`=150.
  - Required: `digits`=24'hHHFFSS (hours and seconds BCD-correct, minutes byte 8'hFF); `range_err`=1 after CONV.
  - Follow-up: a subsequent legal refresh clears `range_err`.
- Busy / ignore:
  - Stimulus: `start` held high for 300 cycles.
  - Required: exactly one refresh, then a second one beginning the cycle after `done`.
  - Stimulus: changing inputs mid-SHIFT.
  - Required: the frame is unchanged.
- Serial protocol, checked at `CLK_DIV`=1 and 7:
  - Exactly 24 `sclk` rising edges per frame.
  - `sdata` never toggles while `sclk` is high.
  - `slatch` width equals `CLK_DIV` and is preceded by `sclk` low.
- Reset mid-SHIFT:
  - Stimulus: assert `rst` after bit 10.
  - Required: all outputs 0 asynchronously; no `slatch` pulse; a next `start` yields a full correct frame.
